// File: rtl/aquisicao_temperatura_if.sv
// Signal bundle between the temperature acquisition block, the serial sensor and the reactor system.
// The master side is the acquisition block; the slave side is its environment.
interface aquisicao_temperatura_if;
    logic       sensorPronto;
    logic       sensorDado;
    logic       sensorIniciar;
    logic       sensorClk;
    logic [8:0] tempRea;
    logic       tempValida;
    logic       falhaSensor;

    modport master (
        input  sensorPronto, sensorDado,
        output sensorIniciar, sensorClk, tempRea, tempValida, falhaSensor
    );

    modport slave (
        output sensorPronto, sensorDado,
        input  sensorIniciar, sensorClk, tempRea, tempValida, falhaSensor
    );
endinterface

// File: rtl/aquisicao_temperatura.sv
// Periodic temperature acquisition: starts a conversion, reads a 13-bit parity-protected serial frame,
// publishes a saturated 9-bit reading and escalates repeated failures into a sticky fail-safe mode.
module aquisicao_temperatura #(
    parameter int PERIODO_AMOSTRA = 1000,
    parameter int TIMEOUT         = 255
) (
    input  logic                    CLOCK,
    input  logic                    reset,
    aquisicao_temperatura_if.master bus
);
    localparam int LEITURA_CICLOS = 26;
    localparam int MAIOR_PT = (PERIODO_AMOSTRA > TIMEOUT) ? PERIODO_AMOSTRA : TIMEOUT;
    localparam int CNT_MAX  = (MAIOR_PT > LEITURA_CICLOS) ? MAIOR_PT : LEITURA_CICLOS;
    localparam int CW       = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ESPERA,
        INICIA,
        CONVERTE,
        LEITURA,
        AVALIA
    } estado_t;

    estado_t       estado, estado_prox;
    logic [CW-1:0] cnt, cnt_prox;
    logic [12:0]   shreg, shreg_prox;
    logic [1:0]    falhas, falhas_prox;
    logic          falha, falha_prox;
    logic [8:0]    temp, temp_prox;
    logic          valida, valida_prox;
    logic          iniciar, sclk;
    logic          evento_falha, atualiza;
    logic [11:0]   dado;

    // Once the last bit is shifted in, the 12 data bits sit above the parity bit.
    assign dado = shreg[12:1];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
        estado_prox  = estado;
        shreg_prox   = shreg;
        falhas_prox  = falhas;
        falha_prox   = falha;
        temp_prox    = temp;
        valida_prox  = 1'b0;
        evento_falha = 1'b0;
        atualiza     = 1'b0;

        case (estado)
            ESPERA: begin
                if (cnt == CW'(PERIODO_AMOSTRA - 1)) estado_prox = INICIA;
            end
            INICIA: begin
                estado_prox = CONVERTE;
            end
            CONVERTE: begin
                // A ready flag arriving in the last allowed cycle still wins over the timeout.
                if (bus.sensorPronto) begin
                    estado_prox = LEITURA;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    estado_prox  = ESPERA;
                    evento_falha = 1'b1;
                end
            end
            LEITURA: begin
                if (cnt[0]) shreg_prox = {shreg[11:0], bus.sensorDado};
                if (cnt == CW'(LEITURA_CICLOS - 1)) estado_prox = AVALIA;
            end
            AVALIA: begin
                estado_prox = ESPERA;
                if (^shreg) begin
                    evento_falha = 1'b1;
                end else begin
                    atualiza    = 1'b1;
                    falhas_prox = 2'd0;
                    temp_prox   = (dado > 12'd511) ? 9'd511 : dado[8:0];
                end
            end
            default: estado_prox = ESPERA;
        endcase

        if (evento_falha) begin
            if (falhas != 2'd3) falhas_prox = falhas + 2'd1;
            if (falhas_prox == 2'd3) falha_prox = 1'b1;
        end

        if (atualiza) valida_prox = 1'b1;

        // Fail-safe: once the sensor is declared bad, every outcome reports the hottest reading.
        if ((atualiza || evento_falha) && falha_prox) begin
            temp_prox   = 9'd511;
            valida_prox = 1'b1;
        end

        cnt_prox = (estado_prox != estado) ? '0 : cnt + CW'(1);
    end

    always_ff @(posedge CLOCK) begin
        if (reset) begin
            estado  <= ESPERA;
            cnt     <= '0;
            shreg   <= '0;
            falhas  <= 2'd0;
            falha   <= 1'b0;
            temp    <= 9'd0;
            valida  <= 1'b0;
            iniciar <= 1'b0;
            sclk    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop load its pre-edge value together.
            estado  <= estado_prox;
            cnt     <= cnt_prox;
            shreg   <= shreg_prox;
            falhas  <= falhas_prox;
            falha   <= falha_prox;
            temp    <= temp_prox;
            valida  <= valida_prox;
            iniciar <= (estado_prox == INICIA);
            sclk    <= (estado_prox == LEITURA) && !cnt_prox[0];
        end
    end

    assign bus.sensorIniciar = iniciar;
    assign bus.sensorClk     = sclk;
    assign bus.tempRea       = temp;
    assign bus.tempValida    = valida;
    assign bus.falhaSensor   = falha;
endmodule

// File: tb/tb_aquisicao_temperatura.sv
// Self-checking bench for aquisicao_temperatura: a sensor model drives frames and a scoreboard
// of expected (reading, cycle) pairs is matched against every tempValida pulse.
module tb_aquisicao_temperatura;
    localparam int P      = 4;
    localparam int TO     = 8;
    localparam int LIMITE = 200;

    typedef struct {
        logic [8:0] temp;
        int         ciclo;
    } esperado_t;

    logic CLOCK = 1'b0;
    logic reset = 1'b1;

    aquisicao_temperatura_if bus ();

    aquisicao_temperatura #(
        .PERIODO_AMOSTRA(P),
        .TIMEOUT        (TO)
    ) dut (
        .CLOCK(CLOCK),
        .reset(reset),
        .bus  (bus)
    );

    always #5 CLOCK = ~CLOCK;

    int        ciclo  = 0;
    int        erros  = 0;
    int        checks = 0;
    esperado_t fila[$];

    function automatic logic [12:0] quadro(input logic [11:0] d, input bit flip);
        return {d, (^d) ^ flip};
    endfunction

    function automatic logic [8:0] satura(input logic [11:0] d);
        return (d > 12'd511) ? 9'd511 : d[8:0];
    endfunction

    // Advances one cycle and matches any tempValida pulse against the scoreboard.
    task automatic tick();
        esperado_t e;
        @(negedge CLOCK);
        ciclo++;
        if (bus.tempValida === 1'b1) begin
            checks++;
            if (fila.size() == 0) begin
                erros++;
                $display("FAIL pulso_inesperado: tempValida=1 tempRea=%0d at cycle %0d, required no pulse",
                         bus.tempRea, ciclo);
            end else begin
                e = fila.pop_front();
                if (bus.tempRea !== e.temp) begin
                    erros++;
                    $display("FAIL valor_pulso: tempRea=%0d, required %0d (cycle %0d)", bus.tempRea, e.temp, ciclo);
                end
                checks++;
                if (ciclo != e.ciclo) begin
                    erros++;
                    $display("FAIL latencia_pulso: pulse at cycle %0d, required cycle %0d", ciclo, e.ciclo);
                end
            end
        end
    endtask

    task automatic espera_iniciar(output int n);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (bus.sensorIniciar !== 1'b1 && k < LIMITE);
        checks++;
        if (bus.sensorIniciar !== 1'b1) begin
            erros++;
            $display("FAIL espera_iniciar: sensorIniciar=%b after %0d cycles, required 1", bus.sensorIniciar, k);
        end
        n = ciclo;
    endtask

    // One acquisition answered by the sensor model: ready after 'espera' cycles, then nbits of the frame.
    task automatic adquire(input logic [11:0] d, input bit flip, input int espera, input int nbits,
                           input bit com_pulso, input logic [8:0] temp_esp);
        int          n, c, k;
        logic [12:0] q;
        esperado_t   e;
        q = quadro(d, flip);
        espera_iniciar(n);
        repeat (espera) tick();
        bus.sensorPronto = 1'b1;
        c = ciclo;
        if (com_pulso) begin
            e.temp  = temp_esp;
            e.ciclo = c + 28;
            fila.push_back(e);
        end
        for (int i = 0; i < nbits; i++) begin
            k = 0;
            do begin
                tick();
                k++;
            end while (bus.sensorClk !== 1'b1 && k < 8);
            checks++;
            if (bus.sensorClk !== 1'b1) begin
                erros++;
                $display("FAIL sensor_clk: sensorClk=%b for bit %0d, required 1", bus.sensorClk, i);
            end
            bus.sensorDado = q[12 - i];
        end
        bus.sensorPronto = 1'b0;
    endtask

    // One acquisition the sensor never answers.
    task automatic adquire_timeout(input bit com_pulso);
        int        n;
        esperado_t e;
        espera_iniciar(n);
        if (com_pulso) begin
            e.temp  = 9'd511;
            e.ciclo = n + TO + 1;
            fila.push_back(e);
        end
        repeat (TO + 3) tick();
    endtask

    task automatic drena();
        int k;
        k = 0;
        while (fila.size() != 0 && k < 40) begin
            tick();
            k++;
        end
        checks++;
        if (fila.size() != 0) begin
            erros++;
            $display("FAIL pulso_ausente: %0d expected pulse(s) never seen, next tempRea %0d at cycle %0d",
                     fila.size(), fila[0].temp, fila[0].ciclo);
            fila.delete();
        end
    endtask

    task automatic test_reset();
        logic [12:0] saida;
        int          c0, n;
        reset = 1'b1;
        repeat (3) tick();
        saida = {bus.tempRea, bus.tempValida, bus.falhaSensor, bus.sensorIniciar, bus.sensorClk};
        checks++;
        if (saida !== 13'd0) begin
            erros++;
            $display("FAIL reset_saidas: outputs=%b, required all 0", saida);
        end
        reset = 1'b0;
        c0 = ciclo;
        espera_iniciar(n);
        checks++;
        if (n - c0 != P) begin
            erros++;
            $display("FAIL primeiro_iniciar: %0d cycles after release, required %0d", n - c0, P);
        end
        tick();
        checks++;
        if (bus.sensorIniciar !== 1'b0) begin
            erros++;
            $display("FAIL largura_iniciar: sensorIniciar=%b one cycle later, required 0", bus.sensorIniciar);
        end
        reset = 1'b1;
        tick();
        saida = {bus.tempRea, bus.tempValida, bus.falhaSensor, bus.sensorIniciar, bus.sensorClk};
        checks++;
        if (saida !== 13'd0) begin
            erros++;
            $display("FAIL reset_converte: outputs=%b, required all 0", saida);
        end
        reset = 1'b0;
    endtask

    task automatic test_good_frame();
        adquire(12'h12C, 1'b0, 3, 13, 1'b1, 9'd300);
        drena();
        repeat (3) tick();
        checks++;
        if (bus.tempRea !== 9'd300 || bus.tempValida !== 1'b0) begin
            erros++;
            $display("FAIL retencao: tempRea=%0d tempValida=%b, required 300 and 0", bus.tempRea, bus.tempValida);
        end
    endtask

    task automatic test_saturation();
        adquire(12'h7D0, 1'b0, 2, 13, 1'b1, 9'd511);
        drena();
    endtask

    task automatic test_parity_error();
        adquire(12'h12C, 1'b0, 1, 13, 1'b1, 9'd300);
        drena();
        adquire(12'h12C, 1'b1, 1, 13, 1'b0, 9'd0);
        repeat (6) tick();
        checks++;
        if (bus.tempRea !== 9'd300 || bus.falhaSensor !== 1'b0) begin
            erros++;
            $display("FAIL paridade: tempRea=%0d falhaSensor=%b, required 300 and 0", bus.tempRea, bus.falhaSensor);
        end
    endtask

    task automatic test_tie();
        adquire(12'h0A5, 1'b0, TO, 13, 1'b1, 9'd165);
        drena();
    endtask

    task automatic test_back_to_back();
        logic [11:0] tabela[4];
        int          espera;
        tabela[0] = 12'd511;
        tabela[1] = 12'd512;
        tabela[2] = 12'($urandom_range(0, 4095));
        tabela[3] = 12'($urandom_range(0, 511));
        for (int i = 0; i < 4; i++) begin
            espera = $urandom_range(1, TO);
            adquire(tabela[i], 1'b0, espera, 13, 1'b1, satura(tabela[i]));
        end
        drena();
    endtask

    task automatic test_reset_mid_frame();
        logic [12:0] saida;
        int          c0, n;
        adquire(12'hABC, 1'b0, 2, 7, 1'b0, 9'd0);
        reset = 1'b1;
        tick();
        saida = {bus.tempRea, bus.tempValida, bus.falhaSensor, bus.sensorIniciar, bus.sensorClk};
        checks++;
        if (saida !== 13'd0) begin
            erros++;
            $display("FAIL reset_leitura: outputs=%b, required all 0", saida);
        end
        reset = 1'b0;
        c0 = ciclo;
        espera_iniciar(n);
        checks++;
        if (n - c0 != P) begin
            erros++;
            $display("FAIL iniciar_pos_reset: %0d cycles after release, required %0d", n - c0, P);
        end
    endtask

    task automatic test_timeout();
        adquire(12'd100, 1'b0, 1, 13, 1'b1, 9'd100);
        drena();
        for (int i = 0; i < 2; i++) begin
            adquire_timeout(1'b0);
            checks++;
            if (bus.falhaSensor !== 1'b0 || bus.tempRea !== 9'd100) begin
                erros++;
                $display("FAIL timeout_%0d: falhaSensor=%b tempRea=%0d, required 0 and 100",
                         i + 1, bus.falhaSensor, bus.tempRea);
            end
        end
        adquire_timeout(1'b1);
        drena();
        checks++;
        if (bus.falhaSensor !== 1'b1 || bus.tempRea !== 9'd511) begin
            erros++;
            $display("FAIL timeout_3: falhaSensor=%b tempRea=%0d, required 1 and 511", bus.falhaSensor, bus.tempRea);
        end
        adquire(12'h12C, 1'b0, 1, 13, 1'b1, 9'd511);
        drena();
        checks++;
        if (bus.falhaSensor !== 1'b1) begin
            erros++;
            $display("FAIL falha_persistente: falhaSensor=%b, required 1", bus.falhaSensor);
        end
    endtask

    initial begin
        bus.sensorPronto = 1'b0;
        bus.sensorDado   = 1'b0;
        test_reset();
        test_good_frame();
        test_saturation();
        test_parity_error();
        test_tie();
        test_back_to_back();
        test_reset_mid_frame();
        test_timeout();
        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", erros, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end
endmodule
